i2c_slave: RTL

- I2C target (responder) for the team's `i2c_master`; it sits on the same SCL/SDA pair, on the far end of the bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP and matches a 7-bit address.
- Write transfers: delivers received bytes on a strobed output. Read transfers: shifts out bytes taken from a user-supplied register.
- Open-drain: the block only ever pulls SDA low; the top level builds the tristate buffer.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_slave_if.sv | 22 ++
 rtl/i2c_bus_sync.sv | 88 ++++++++
 rtl/i2c_slave.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings (also driven on the debug
// state port), ACK/NACK levels, the read/write bit and small bus helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6,
        IGNORE    = 3'd7
    } i2c_state_e;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    // The general-call address (0) is never claimed.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[7:1] != 7'd0);
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Bus and user-side handshake signals of the I2C target.
interface i2c_slave_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic [2:0] state;

    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, state
    );

    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, state
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and START/STOP/edge detector, shared with i2c_master.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter.
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_dly_q, scl_dly_d;
    logic sda_dly_q, sda_dly_d;
    logic scl_f, sda_f;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_dly_d  = scl_f;
        sda_dly_d  = sda_f;
    end

    // Idle bus is high on both lines, so everything resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, scl_hist_d;
    logic [2:0] sda_hist_q, sda_hist_d;
    logic       scl_maj_q, scl_maj_d;
    logic       sda_maj_q, sda_maj_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
        sda_hist_d = {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
        scl_maj_d  = maj3(scl_hist_q);
        sda_maj_d  = maj3(sda_hist_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_maj_q  <= 1'b1;
            sda_maj_q  <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_maj_q  <= scl_maj_d;
            sda_maj_q  <= sda_maj_d;
        end
    end

    assign scl_f = scl_maj_q;
    assign sda_f = sda_maj_q;
`else
    assign scl_f = scl_sync_q[SYNC_STAGES-1];
    assign sda_f = sda_sync_q[SYNC_STAGES-1];
`endif

    assign sda_s    = sda_f;
    assign scl_rise = scl_f & ~scl_dly_q;
    assign scl_fall = ~scl_f & scl_dly_q;
    // SCL must be stably high across both samples for a START/STOP.
    assign start    = scl_f & scl_dly_q & sda_dly_q & ~sda_f;
    assign stop     = scl_f & scl_dly_q & ~sda_dly_q & sda_f;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write bytes out on rx_*, read bytes from tx_*.
// Optional I2C_SLAVE_GLITCH_FILTER_EN enables the bus glitch filter.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h2A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        reset,
    i2c_slave_if.slave bus
);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (bus.scl),
        .sda      (bus.sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       tx_req_c;
    logic [7:0] shift_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        tx_req_c   = 1'b0;
        shift_in   = {shift_q[6:0], sda_s};

        if (start) begin
            state_d  = ADDR;
            cnt_d    = '0;
            shift_d  = '0;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (addr_match(shift_in, SLAVE_ADDR)) begin
                            rw_d    = shift_in[0];
                            busy_d  = 1'b1;
                            phase_d = 1'b0;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                // phase 0: first fall starts the ACK; phase 1: second fall ends it.
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = ~ACK;
                        phase_d  = 1'b1;
                        if (rw_q == RW_READ) begin
                            tx_req_c = 1'b1;
                            shift_d  = bus.tx_data;
                        end
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = '0;
                        if (rw_q == RW_READ) begin
                            sda_oe_d = ~shift_q[7];
                            state_d  = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WRITE;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        phase_d    = 1'b0;
                        state_d    = WRITE_ACK;
                    end
                end
                WRITE_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = ~ACK;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        cnt_d    = '0;
                        state_d  = WRITE;
                    end
                end
                READ: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = READ_ACK;
                    end else begin
                        sda_oe_d = ~shift_q[6];
                        shift_d  = {shift_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 3'd1;
                    end
                end
                // phase records that the master ACKed; reload happens on the next fall.
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) phase_d = 1'b1;
                        else              state_d = IGNORE;
                    end else if (scl_fall && phase_q) begin
                        tx_req_c = 1'b1;
                        shift_d  = bus.tx_data;
                        sda_oe_d = ~bus.tx_data[7];
                        cnt_d    = '0;
                        phase_d  = 1'b0;
                        state_d  = READ;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_c;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;

endmodule
